// File: rtl/clock_pkg.sv
// Shared definitions for the clock counter chain and its time-setting front end:
// counter widths, default wrap limits, edit state encoding and field select codes.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 7;
    localparam int SEC_W  = 6;

    localparam int unsigned DEFAULT_HOUR_MAX = 23;
    localparam int unsigned DEFAULT_MIN_MAX  = 59;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        EDIT_HOUR = 2'b01,
        EDIT_MIN  = 2'b10,
        COMMIT    = 2'b11
    } set_state_t;

    typedef enum logic [1:0] {
        FIELD_NONE    = 2'b00,
        FIELD_HOURS   = 2'b01,
        FIELD_MINUTES = 2'b10
    } field_sel_t;

    // Step a counter value by one, wrapping to zero once it has reached its limit.
    // A value already beyond the limit also wraps, so a shadow can never run away.
    function automatic logic [7:0] wrapInc(input logic [7:0] value, input logic [7:0] maxValue);
        return (value >= maxValue) ? 8'd0 : value + 8'd1;
    endfunction

endpackage

// File: rtl/time_set_controller_rise_detect.sv
// Rising-edge detector for one debounced button level. A held button reports a
// single press on its leading edge; the press output is combinational so the
// consumer sees it at the first clock edge after the level rises.
module rise_detect (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    // Remember last cycle's level so only a low-to-high change counts as a press
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/time_set_controller.sv
// Front-panel time setting controller. Mode presses walk RUN -> EDIT_HOUR ->
// EDIT_MIN -> COMMIT -> RUN; inc presses bump the shadow copy of the field being
// edited. COMMIT issues a one-cycle load strobe carrying the shadow hour/minute
// and zero seconds to the counter chain. A blink enable toggles once per second
// while a field is being edited.
// Optional feature macro: SET_TIMEOUT_EN -- abandon an edit (no load) after
// TIMEOUT_S seconds without any button press.
module time_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned HOUR_MAX  = DEFAULT_HOUR_MAX,
    parameter int unsigned MIN_MAX   = DEFAULT_MIN_MAX
`ifdef SET_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_S = 30
`endif
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              tick_1hz_i,
    input  logic              btn_mode_i,
    input  logic              btn_inc_i,
    input  logic [HOUR_W-1:0] cur_hours_i,
    input  logic [MIN_W-1:0]  cur_minutes_i,
    output logic              set_o,
    output logic [HOUR_W-1:0] set_hours_o,
    output logic [MIN_W-1:0]  set_minutes_o,
    output logic [SEC_W-1:0]  set_seconds_o,
    output logic              editing_o,
    output logic [1:0]        field_sel_o,
    output logic              blink_o
);

    set_state_t        state_q;
    field_sel_t        fieldSel_q;
    logic [HOUR_W-1:0] shHour_q;
    logic [MIN_W-1:0]  shMin_q;
    logic              set_q;
    logic              editing_q;
    logic              blink_q;

    logic              modePress;
    logic              incPress;
    logic [HOUR_W-1:0] shHour_d;
    logic [MIN_W-1:0]  shMin_d;
    logic              timeoutHit;

    rise_detect u_modeRise (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .level_i   (btn_mode_i),
        .rise_o    (modePress)
    );

    rise_detect u_incRise (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .level_i   (btn_inc_i),
        .rise_o    (incPress)
    );

    // Candidate wrapped increments for each shadow, used only on an inc press
    always_comb begin
        shHour_d = HOUR_W'(wrapInc(8'(shHour_q), 8'(HOUR_MAX)));
        shMin_d  = MIN_W'(wrapInc(8'(shMin_q), 8'(MIN_MAX)));
    end

`ifdef SET_TIMEOUT_EN
    localparam int IDLE_W = 6;
    localparam logic [IDLE_W-1:0] IdleLast = IDLE_W'(TIMEOUT_S - 1);

    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;
    logic              inEdit;

    assign inEdit = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN);

    // Idle seconds since the last press or state change; any press outranks a
    // tick that would otherwise complete the timeout
    always_comb begin
        idle_d     = idle_q;
        timeoutHit = 1'b0;
        if (modePress || incPress || !inEdit) begin
            idle_d = '0;
        end else if (tick_1hz_i) begin
            if (idle_q >= IdleLast) begin
                idle_d     = '0;
                timeoutHit = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    // Idle counter register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    // Edit state machine with registered strobe, field decode, blink and shadows
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= RUN;
            fieldSel_q <= FIELD_NONE;
            shHour_q   <= '0;
            shMin_q    <= '0;
            set_q      <= 1'b0;
            editing_q  <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            set_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    if (modePress) begin
                        state_q    <= EDIT_HOUR;
                        shHour_q   <= cur_hours_i;
                        shMin_q    <= cur_minutes_i;
                        editing_q  <= 1'b1;
                        fieldSel_q <= FIELD_HOURS;
                    end
                    blink_q <= 1'b0;
                end
                EDIT_HOUR: begin
                    if (modePress) begin
                        state_q    <= EDIT_MIN;
                        fieldSel_q <= FIELD_MINUTES;
                        blink_q    <= 1'b0;
                    end else if (timeoutHit) begin
                        state_q    <= RUN;
                        editing_q  <= 1'b0;
                        fieldSel_q <= FIELD_NONE;
                        blink_q    <= 1'b0;
                    end else begin
                        if (incPress) begin
                            shHour_q <= shHour_d;
                        end
                        if (tick_1hz_i) begin
                            blink_q <= ~blink_q;
                        end
                    end
                end
                EDIT_MIN: begin
                    if (modePress) begin
                        state_q    <= COMMIT;
                        set_q      <= 1'b1;
                        editing_q  <= 1'b0;
                        fieldSel_q <= FIELD_NONE;
                        blink_q    <= 1'b0;
                    end else if (timeoutHit) begin
                        state_q    <= RUN;
                        editing_q  <= 1'b0;
                        fieldSel_q <= FIELD_NONE;
                        blink_q    <= 1'b0;
                    end else begin
                        if (incPress) begin
                            shMin_q <= shMin_d;
                        end
                        if (tick_1hz_i) begin
                            blink_q <= ~blink_q;
                        end
                    end
                end
                COMMIT: begin
                    state_q <= RUN;
                    blink_q <= 1'b0;
                end
                default: begin
                    state_q    <= RUN;
                    editing_q  <= 1'b0;
                    fieldSel_q <= FIELD_NONE;
                    blink_q    <= 1'b0;
                end
            endcase
        end
    end

    assign set_o         = set_q;
    assign set_hours_o   = shHour_q;
    assign set_minutes_o = shMin_q;
    assign set_seconds_o = '0;
    assign editing_o     = editing_q;
    assign field_sel_o   = fieldSel_q;
    assign blink_o       = blink_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: fixed vector table, hand-written corner
// sequences and a randomized run against a behavioural model of the edit rules.
module tb_time_set_controller;

    localparam int HOURS_PER_DAY  = 24;
    localparam int MINS_PER_HOUR  = 60;
`ifdef SET_TIMEOUT_EN
    localparam int IDLE_LIMIT     = 3;
`endif

    localparam int PH_RUN    = 0;
    localparam int PH_HOUR   = 1;
    localparam int PH_MIN    = 2;
    localparam int PH_COMMIT = 3;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       tick = 1'b0;
    logic       btnMode = 1'b0;
    logic       btnInc = 1'b0;
    logic [4:0] curHours = '0;
    logic [6:0] curMinutes = '0;
    logic       setO;
    logic [4:0] setHours;
    logic [6:0] setMinutes;
    logic [5:0] setSeconds;
    logic       editing;
    logic [1:0] fieldSel;
    logic       blink;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int mPhase;
    int mH;
    int mM;
    int mIdle;
    bit mBlink;
    bit mPrevMode;
    bit mPrevInc;

    typedef struct {
        int m, i, t, ch, cm;
        int eSet, eEdit, eField, eBlink, eH, eM;
    } vec_t;

    vec_t vecs[$];

    time_set_controller #(
        .HOUR_MAX (23),
        .MIN_MAX  (59)
`ifdef SET_TIMEOUT_EN
        ,
        .TIMEOUT_S (3)
`endif
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (resetN),
        .tick_1hz_i    (tick),
        .btn_mode_i    (btnMode),
        .btn_inc_i     (btnInc),
        .cur_hours_i   (curHours),
        .cur_minutes_i (curMinutes),
        .set_o         (setO),
        .set_hours_o   (setHours),
        .set_minutes_o (setMinutes),
        .set_seconds_o (setSeconds),
        .editing_o     (editing),
        .field_sel_o   (fieldSel),
        .blink_o       (blink)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mPhase    = PH_RUN;
        mH        = 0;
        mM        = 0;
        mIdle     = 0;
        mBlink    = 1'b0;
        mPrevMode = 1'b0;
        mPrevInc  = 1'b0;
    endtask

    // One clock edge of the edit rules, written from the button/press semantics
    task automatic modelStep(input int m, input int i, input int t, input int ch, input int cm);
        bit modeP;
        bit incP;
        bit abort;
        modeP     = (m != 0) && !mPrevMode;
        incP      = (i != 0) && !mPrevInc;
        mPrevMode = (m != 0);
        mPrevInc  = (i != 0);
        abort     = 1'b0;
        if (mPhase == PH_RUN) begin
            if (modeP) begin
                mPhase = PH_HOUR;
                mH     = ch;
                mM     = cm;
                mIdle  = 0;
            end
            mBlink = 1'b0;
        end else if (mPhase == PH_COMMIT) begin
            mPhase = PH_RUN;
            mBlink = 1'b0;
        end else if (modeP) begin
            mPhase = mPhase + 1;
            mBlink = 1'b0;
            mIdle  = 0;
        end else begin
            if (incP) begin
                if (mPhase == PH_HOUR) mH = (mH + 1) % HOURS_PER_DAY;
                else                   mM = (mM + 1) % MINS_PER_HOUR;
                mIdle = 0;
            end else if (t != 0) begin
                mIdle++;
`ifdef SET_TIMEOUT_EN
                if (mIdle >= IDLE_LIMIT) abort = 1'b1;
`endif
            end
            if (abort) begin
                mPhase = PH_RUN;
                mBlink = 1'b0;
                mIdle  = 0;
            end else if (t != 0) begin
                mBlink = !mBlink;
            end
        end
    endtask

    task automatic checkOne(input string tag, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int eSet, input int eEdit, input int eField,
                               input int eBlink, input int eH, input int eM);
        checkOne(tag, "set",         int'(setO),       eSet);
        checkOne(tag, "editing",     int'(editing),    eEdit);
        checkOne(tag, "field_sel",   int'(fieldSel),   eField);
        checkOne(tag, "blink",       int'(blink),      eBlink);
        checkOne(tag, "set_hours",   int'(setHours),   eH);
        checkOne(tag, "set_minutes", int'(setMinutes), eM);
        checkOne(tag, "set_seconds", int'(setSeconds), 0);
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag,
                    (mPhase == PH_COMMIT) ? 1 : 0,
                    (mPhase == PH_HOUR || mPhase == PH_MIN) ? 1 : 0,
                    (mPhase == PH_HOUR) ? 1 : ((mPhase == PH_MIN) ? 2 : 0),
                    mBlink ? 1 : 0, mH, mM);
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, settle
    task automatic applyStimulus(input int m, input int i, input int t);
        btnMode = (m != 0);
        btnInc  = (i != 0);
        tick    = (t != 0);
        @(posedge clk);
        modelStep(m, i, t, int'(curHours), int'(curMinutes));
        #1;
    endtask

    // Assert reset between edges, confirm outputs drop without a clock, release
    task automatic doReset(input string tag);
        btnMode = 1'b0;
        btnInc  = 1'b0;
        tick    = 1'b0;
        resetN  = 1'b0;
        #1;
        checkOutput(tag, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        modelReset();
    endtask

    task automatic addVec(input int m, input int i, input int t, input int ch, input int cm,
                          input int s, input int e, input int f, input int b, input int h, input int mm);
        vec_t v;
        v.m = m;  v.i = i;  v.t = t;  v.ch = ch;  v.cm = cm;
        v.eSet = s;  v.eEdit = e;  v.eField = f;  v.eBlink = b;  v.eH = h;  v.eM = mm;
        vecs.push_back(v);
    endtask

    initial begin
        modelReset();
        #3;
        doReset("por");

        //     mode inc tick  curH curM   set ed fld blk  h   m
        addVec(0, 0, 0, 13, 45,   0, 0, 0, 0,  0,  0);
        addVec(1, 0, 0, 13, 45,   0, 1, 1, 0, 13, 45);
        addVec(0, 0, 0, 13, 45,   0, 1, 1, 0, 13, 45);
        addVec(1, 0, 0, 13, 45,   0, 1, 2, 0, 13, 45);
        addVec(0, 0, 0, 13, 45,   0, 1, 2, 0, 13, 45);
        addVec(1, 0, 0, 13, 45,   1, 0, 0, 0, 13, 45);
        addVec(0, 0, 0, 13, 45,   0, 0, 0, 0, 13, 45);
        addVec(0, 0, 0, 22, 58,   0, 0, 0, 0, 13, 45);
        addVec(1, 0, 0, 22, 58,   0, 1, 1, 0, 22, 58);
        addVec(0, 0, 0, 22, 58,   0, 1, 1, 0, 22, 58);
        addVec(0, 1, 0, 22, 58,   0, 1, 1, 0, 23, 58);
        addVec(0, 0, 0, 22, 58,   0, 1, 1, 0, 23, 58);
        addVec(0, 1, 0, 22, 58,   0, 1, 1, 0,  0, 58);
        addVec(0, 0, 0, 22, 58,   0, 1, 1, 0,  0, 58);
        addVec(0, 1, 0, 22, 58,   0, 1, 1, 0,  1, 58);
        addVec(0, 0, 0, 22, 58,   0, 1, 1, 0,  1, 58);
        addVec(1, 0, 0, 22, 58,   0, 1, 2, 0,  1, 58);
        addVec(0, 0, 0, 22, 58,   0, 1, 2, 0,  1, 58);
        addVec(0, 1, 0, 22, 58,   0, 1, 2, 0,  1, 59);
        addVec(0, 0, 0, 22, 58,   0, 1, 2, 0,  1, 59);
        addVec(0, 1, 0, 22, 58,   0, 1, 2, 0,  1,  0);
        addVec(0, 0, 0, 22, 58,   0, 1, 2, 0,  1,  0);
        addVec(0, 0, 1, 22, 58,   0, 1, 2, 1,  1,  0);
        addVec(0, 0, 0, 22, 58,   0, 1, 2, 1,  1,  0);
        addVec(0, 0, 1, 22, 58,   0, 1, 2, 0,  1,  0);
        addVec(1, 0, 0, 22, 58,   1, 0, 0, 0,  1,  0);
        addVec(0, 0, 0, 22, 58,   0, 0, 0, 0,  1,  0);
        addVec(0, 0, 1, 22, 58,   0, 0, 0, 0,  1,  0);
        addVec(0, 1, 0, 22, 58,   0, 0, 0, 0,  1,  0);
        addVec(0, 0, 0, 22, 58,   0, 0, 0, 0,  1,  0);
        addVec(1, 0, 1,  4,  5,   0, 1, 1, 0,  4,  5);
        addVec(0, 0, 0,  4,  5,   0, 1, 1, 0,  4,  5);

        for (int k = 0; k < vecs.size(); k++) begin
            curHours   = 5'(vecs[k].ch);
            curMinutes = 7'(vecs[k].cm);
            applyStimulus(vecs[k].m, vecs[k].i, vecs[k].t);
            checkOutput($sformatf("vec%0d", k), vecs[k].eSet, vecs[k].eEdit, vecs[k].eField,
                        vecs[k].eBlink, vecs[k].eH, vecs[k].eM);
        end

        // Held inc button gives exactly one increment; mode beats a simultaneous inc
        doReset("holdReset");
        curHours = 5'd5;
        curMinutes = 7'd10;
        applyStimulus(1, 0, 0);
        checkOutput("holdEnter", 0, 1, 1, 0, 5, 10);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        checkOutput("holdFirst", 0, 1, 1, 0, 6, 10);
        repeat (99) applyStimulus(0, 1, 0);
        checkOutput("holdEnd", 0, 1, 1, 0, 6, 10);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 1, 0);
        checkOutput("modeWins", 0, 1, 2, 0, 6, 10);
        applyStimulus(0, 0, 0);

        // Reset in the middle of an edit clears everything at once
        doReset("editReset");

        // Reset while the load strobe is high drops it without a clock edge
        curHours = 5'd9;
        curMinutes = 7'd30;
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("commitSet", 1, 0, 0, 0, 9, 30);
        doReset("commitReset");
        repeat (3) applyStimulus(0, 0, 0);
        checkOutput("postResetIdle", 0, 0, 0, 0, 0, 0);

        // Blink follows ticks only while editing and is cleared on every entry/exit
        curHours = 5'd1;
        curMinutes = 7'd2;
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 1);
        checkOutput("blinkOn", 0, 1, 1, 1, 1, 2);
        applyStimulus(0, 0, 1);
        checkOutput("blinkOff", 0, 1, 1, 0, 1, 2);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 0);
        checkOutput("blinkEntry", 0, 1, 2, 0, 1, 2);
        applyStimulus(0, 0, 1);
        checkOutput("blinkMin", 0, 1, 2, 1, 1, 2);
        applyStimulus(1, 0, 0);
        checkOutput("blinkCommit", 1, 0, 0, 0, 1, 2);
        applyStimulus(0, 0, 1);
        checkOutput("blinkRun", 0, 0, 0, 0, 1, 2);
        applyStimulus(0, 0, 1);
        checkOutput("blinkRunTick", 0, 0, 0, 0, 1, 2);

`ifdef SET_TIMEOUT_EN
        // Three idle ticks abandon the edit; a press on the third tick keeps it alive
        doReset("toReset");
        curHours = 5'd7;
        curMinutes = 7'd8;
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("toEnter", 0, 1, 2, 0, 7, 8);
        applyStimulus(0, 0, 1);
        checkOutput("toTick1", 0, 1, 2, 1, 7, 8);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        checkOutput("toTick2", 0, 1, 2, 0, 7, 8);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        checkOutput("timeoutAbort", 0, 0, 0, 0, 7, 8);
        applyStimulus(0, 0, 0);
        checkOutput("timeoutNoSet", 0, 0, 0, 0, 7, 8);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 1);
        checkOutput("timeoutPressWins", 0, 1, 2, 1, 7, 9);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        checkOutput("timeoutCountOn", 0, 1, 2, 1, 7, 9);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        checkOutput("timeoutRestart", 0, 0, 0, 0, 7, 9);
`endif

        // Randomized buttons, ticks and live time against the model
        doReset("rndReset");
        for (int n = 0; n < 1500; n++) begin
            curHours   = 5'($urandom_range(HOURS_PER_DAY - 1, 0));
            curMinutes = 7'($urandom_range(MINS_PER_HOUR - 1, 0));
            applyStimulus(($urandom_range(4, 0) == 0) ? 1 : 0,
                          ($urandom_range(2, 0) == 0) ? 1 : 0,
                          ($urandom_range(5, 0) == 0) ? 1 : 0);
            checkModel($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
